// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and register writeback, stalling upstream while a req/ack transaction is open
module mem_wb_stage #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                   mw_clk,
  input  logic                   mw_rst,
  input  logic                   mw_i_ce,
  input  logic                   mw_i_flush,
  input  logic                   mw_i_load,
  input  logic                   mw_i_store,
  input  logic [FUNCT_WIDTH-1:0] mw_i_funct3,
  input  logic [DWIDTH-1:0]      mw_i_alu_value,
  input  logic [DWIDTH-1:0]      mw_i_data_rs2,
  input  logic [AWIDTH-1:0]      mw_i_addr_rd,
  input  logic                   mw_i_we_reg,
  input  logic [PC_WIDTH-1:0]    mw_i_pc,
  output logic                   mw_o_stall,
  output logic                   mw_o_req,
  output logic                   mw_o_we,
  output logic [DWIDTH-1:0]      mw_o_addr,
  output logic [DWIDTH-1:0]      mw_o_wdata,
  output logic [3:0]             mw_o_wstrb,
  input  logic                   mw_i_ack,
  input  logic [DWIDTH-1:0]      mw_i_rdata,
  output logic                   mw_o_valid,
  output logic                   mw_o_we_reg,
  output logic [AWIDTH-1:0]      mw_o_addr_rd,
  output logic [DWIDTH-1:0]      mw_o_data_rd,
  output logic [PC_WIDTH-1:0]    mw_o_pc,
  output logic                   mw_o_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, valid_q, valid_d, we_reg_q, we_reg_d;
  logic err_q, err_d, flush_q, flush_d, wr_q, wr_d;
  logic [DWIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, data_rd_q, data_rd_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [AWIDTH-1:0] addr_rd_q, addr_rd_d, rd_q, rd_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pcl_q, pcl_d;
  logic [FUNCT_WIDTH-1:0] f3_q, f3_d;
  logic [1:0] off_q, off_d, off;
  logic acc, mem, illegal, misal, wr, flushed;
  logic [DWIDTH-1:0] sh, ld_data;
  assign off     = mw_i_alu_value[1:0];
  assign acc     = mw_i_ce & ~mw_i_flush;
  assign mem     = mw_i_load | mw_i_store;
  assign illegal = mw_i_store ? (mw_i_funct3 > 3'd2) : (mw_i_funct3 == 3'b011 || mw_i_funct3[2:1] == 2'b11);
  assign misal   = (mw_i_funct3[1:0] == 2'b01 && off[0]) || (mw_i_funct3[1:0] == 2'b10 && off != 2'b00);
  assign wr      = mw_i_we_reg & (mw_i_addr_rd != '0);
  assign flushed = flush_q | mw_i_flush;
  assign sh      = mw_i_rdata >> {off_q, 3'b000};
  // funct3[2] selects the unsigned load variants
  assign ld_data = f3_q[1] ? mw_i_rdata :
                   f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} :
                             {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    data_rd_d = data_rd_q;
    addr_rd_d = addr_rd_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    pcl_d     = pcl_q;
    f3_d      = f3_q;
    off_d     = off_q;
    wr_d      = wr_q;
    flush_d   = flush_q;
    valid_d   = 1'b0;
    we_reg_d  = 1'b0;
    err_d     = 1'b0;
    if (state_q == IDLE) begin
      if (acc && !mem) begin
        valid_d   = 1'b1;
        we_reg_d  = wr;
        data_rd_d = mw_i_alu_value;
        addr_rd_d = mw_i_addr_rd;
        pc_d      = mw_i_pc;
      end else if (acc && (illegal || misal)) begin
        valid_d   = 1'b1;
        err_d     = 1'b1;
        addr_rd_d = mw_i_addr_rd;
        pc_d      = mw_i_pc;
      end else if (acc) begin
        state_d = WAIT;
        req_d   = 1'b1;
        we_d    = mw_i_store;
        addr_d  = {mw_i_alu_value[DWIDTH-1:2], 2'b00};
        wdata_d = mw_i_funct3[1] ? mw_i_data_rs2 :
                  mw_i_funct3[0] ? {2{mw_i_data_rs2[15:0]}} : {4{mw_i_data_rs2[7:0]}};
        wstrb_d = mw_i_funct3[1] ? 4'b1111 :
                  mw_i_funct3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
        f3_d    = mw_i_funct3;
        off_d   = off;
        rd_d    = mw_i_addr_rd;
        pcl_d   = mw_i_pc;
        wr_d    = wr;
      end
    end else begin
      flush_d = flushed;
      if (mw_i_ack) begin
        state_d = IDLE;
        req_d   = 1'b0;
        flush_d = 1'b0;
        if (!flushed) begin
          valid_d   = 1'b1;
          we_reg_d  = wr_q & ~we_q;
          data_rd_d = we_q ? '0 : ld_data;
          addr_rd_d = rd_q;
          pc_d      = pcl_q;
        end
      end
    end
  end
  always_ff @(posedge mw_clk or negedge mw_rst) begin
    if (!mw_rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      data_rd_q <= '0;
      addr_rd_q <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      pcl_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      wr_q      <= 1'b0;
      flush_q   <= 1'b0;
      valid_q   <= 1'b0;
      we_reg_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      data_rd_q <= data_rd_d;
      addr_rd_q <= addr_rd_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      pcl_q     <= pcl_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      flush_q   <= flush_d;
      valid_q   <= valid_d;
      we_reg_q  <= we_reg_d;
      err_q     <= err_d;
    end
  end
  assign mw_o_stall   = (state_q == WAIT);
  assign mw_o_req     = req_q;
  assign mw_o_we      = we_q;
  assign mw_o_addr    = addr_q;
  assign mw_o_wdata   = wdata_q;
  assign mw_o_wstrb   = wstrb_q;
  assign mw_o_valid   = valid_q;
  assign mw_o_we_reg  = we_reg_q;
  assign mw_o_addr_rd = addr_rd_q;
  assign mw_o_data_rd = data_rd_q;
  assign mw_o_pc      = pc_q;
  assign mw_o_err     = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random transactions checked against a transaction-level model
module tb_mem_wb_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ce = 1'b0, flush = 1'b0, load = 1'b0, store = 1'b0, we_reg = 1'b0, ack = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] alu = '0, rs2 = '0, pc = '0, rdata = '0;
  logic [4:0] rd = '0;
  logic stall, req, we, valid, o_we_reg, err;
  logic [31:0] addr, wdata, data_rd, o_pc;
  logic [3:0] wstrb;
  logic [4:0] addr_rd;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  mem_wb_stage dut (
    .mw_clk(clk), .mw_rst(rst_n), .mw_i_ce(ce), .mw_i_flush(flush), .mw_i_load(load),
    .mw_i_store(store), .mw_i_funct3(funct3), .mw_i_alu_value(alu), .mw_i_data_rs2(rs2),
    .mw_i_addr_rd(rd), .mw_i_we_reg(we_reg), .mw_i_pc(pc), .mw_o_stall(stall), .mw_o_req(req),
    .mw_o_we(we), .mw_o_addr(addr), .mw_o_wdata(wdata), .mw_o_wstrb(wstrb), .mw_i_ack(ack),
    .mw_i_rdata(rdata), .mw_o_valid(valid), .mw_o_we_reg(o_we_reg), .mw_o_addr_rd(addr_rd),
    .mw_o_data_rd(data_rd), .mw_o_pc(o_pc), .mw_o_err(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // access size in bytes, 0 when the funct3 is not a legal access of that kind
  function automatic int size_of(input bit st, input logic [2:0] f);
    if (f == 3'd0 || (!st && f == 3'd4)) return 1;
    if (f == 3'd1 || (!st && f == 3'd5)) return 2;
    if (f == 3'd2) return 4;
    return 0;
  endfunction
  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] w, input int off);
    logic [31:0] s = w >> (8 * off);
    logic [31:0] b = s & 32'hFF, h = s & 32'hFFFF;
    if (f == 3'd0) return b + ((b >= 128) ? 32'hFFFF_FF00 : 32'h0);
    if (f == 3'd4) return b;
    if (f == 3'd1) return h + ((h >= 32768) ? 32'hFFFF_0000 : 32'h0);
    if (f == 3'd5) return h;
    return w;
  endfunction
  // fl_wait: 0 never flush in WAIT, 1 random, 2 every cycle
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d2, input logic [4:0] r, input bit w, input logic [31:0] p,
                        input int lat, input int fl_wait, input logic [31:0] mem_word, input bit fl_acc);
    int sz = size_of(st, f), off = int'(a[1:0]);
    bit mem = ld | st, bad, fl = 0, exp_wr = w && (r != 0);
    bad = (sz == 0) || (off % sz != 0);
    ack = ($urandom % 4 == 0);
    rdata = $urandom;
    @(negedge clk);
    ack = 1'b0;
    check("idle_valid", valid, 0); check("idle_err", err, 0); check("idle_stall", stall, 0); check("idle_req", req, 0);
    ce = 1'b1; flush = fl_acc; load = ld; store = st; funct3 = f; alu = a; rs2 = d2; rd = r; we_reg = w; pc = p;
    @(negedge clk);
    ce = 1'b0; flush = 1'b0;
    if (fl_acc) begin
      check("flushacc_valid", valid, 0); check("flushacc_stall", stall, 0); check("flushacc_req", req, 0);
    end else if (!mem) begin
      check("alu_valid", valid, 1); check("alu_we_reg", o_we_reg, exp_wr); check("alu_data", data_rd, a);
      check("alu_rd", addr_rd, r); check("alu_pc", o_pc, p); check("alu_err", err, 0); check("alu_stall", stall, 0);
    end else if (bad) begin
      check("bad_valid", valid, 1); check("bad_err", err, 1); check("bad_we_reg", o_we_reg, 0);
      check("bad_req", req, 0); check("bad_stall", stall, 0); check("bad_pc", o_pc, p);
    end else begin
      logic [31:0] ew = (sz == 1) ? d2[7:0] * 32'h0101_0101 : (sz == 2) ? d2[15:0] * 32'h0001_0001 : d2;
      logic [31:0] es = ((32'd1 << sz) - 1) << off;
      logic [31:0] ea = a - off;
      check("mem_req", req, 1); check("mem_we", we, st); check("mem_addr", addr, ea); check("mem_stall", stall, 1);
      if (st) begin check("st_wdata", wdata, ew); check("st_wstrb", {28'd0, wstrb}, es); end
      repeat (lat) begin
        ce = $urandom; alu = $urandom; load = $urandom; store = $urandom; funct3 = $urandom;
        flush = (fl_wait == 2) || (fl_wait == 1 && $urandom % 3 == 0);
        @(negedge clk);
        fl |= flush;
        check("wait_req", req, 1); check("wait_stall", stall, 1); check("wait_addr", addr, ea);
        check("wait_valid", valid, 0);
        if (st) begin check("wait_wdata", wdata, ew); check("wait_wstrb", {28'd0, wstrb}, es); end
      end
      ack = 1'b1; rdata = mem_word;
      flush = (fl_wait == 2) || (fl_wait == 1 && $urandom % 3 == 0);
      @(negedge clk);
      fl |= flush;
      ack = 1'b0; flush = 1'b0; ce = 1'b0;
      check("ret_valid", valid, !fl); check("ret_req", req, 0); check("ret_stall", stall, 0);
      check("ret_we_reg", o_we_reg, !fl && !st && exp_wr);
      if (!fl) begin
        check("ret_data", data_rd, st ? 32'h0 : load_val(f, mem_word, off));
        check("ret_rd", addr_rd, r); check("ret_pc", o_pc, p);
      end
    end
    load = 1'b0; store = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_valid", valid, 0); check("rst_req", req, 0); check("rst_stall", stall, 0);
    check("rst_data", data_rd, 0); check("rst_wstrb", {28'd0, wstrb}, 0); check("rst_pc", o_pc, 0);
    @(negedge clk); rst_n = 1'b1;
    // reset while a load is pending
    @(negedge clk);
    ce = 1'b1; load = 1'b1; funct3 = 3'd2; alu = 32'h40; rd = 5'd3; we_reg = 1'b1;
    @(negedge clk);
    ce = 1'b0; load = 1'b0;
    check("pre_rst_req", req, 1);
    #2 rst_n = 1'b0;
    #1 check("midrst_req", req, 0); check("midrst_stall", stall, 0); check("midrst_valid", valid, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(0, 0, 3'd0, 32'h0000_1234, 0, 5'd5, 1, 32'h10, 0, 0, 0, 0);
    run_op(1, 0, 3'd0, 32'h0000_0103, 0, 5'd9, 1, 32'h14, 3, 0, 32'h80AA_5511, 0);
    run_op(0, 1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 5'd4, 1, 32'h18, 2, 0, 0, 0);
    run_op(1, 0, 3'd2, 32'h0000_0101, 0, 5'd6, 1, 32'h1C, 0, 0, 0, 0);
    run_op(1, 0, 3'd2, 32'h0000_0100, 0, 5'd0, 1, 32'h20, 1, 0, 32'h1234_5678, 0);
    run_op(1, 0, 3'd4, 32'h0000_0102, 0, 5'd7, 1, 32'h24, 2, 2, 32'hDEAD_BEEF, 0);
    run_op(0, 0, 3'd0, 32'h0000_0077, 0, 5'd8, 1, 32'h28, 0, 0, 0, 0);
    run_op(1, 1, 3'd0, 32'h0000_0301, 32'h0000_00A5, 5'd2, 1, 32'h2C, 1, 0, 0, 0);
    run_op(1, 0, 3'd3, 32'h0000_0300, 0, 5'd2, 1, 32'h30, 0, 0, 0, 0);
    run_op(0, 0, 3'd0, 32'h0000_0055, 0, 5'd2, 1, 32'h34, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      int k = $urandom % 4;
      run_op(k == 1 || k == 3, k >= 2, 3'($urandom), $urandom, $urandom, 5'($urandom % 8), 1'($urandom),
             $urandom, $urandom % 5, ($urandom % 4 == 0) ? 1 : 0, $urandom, $urandom % 10 == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
